// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
//   Shared definitions for the trace rendering path: coordinate/colour widths,
//   the largest legal row, the pixel counter width and the two-state encoding
//   shared by the display state machine, the clear block and trace_plotter.
// ---------------------------------------------------------------------------
package trace_pkg;

    localparam int COORD_W = 8;    // width of x and y coordinates
    localparam int COLOR_W = 12;   // 4:4:4 RGB pixel colour
    localparam int Y_MAX   = 239;  // largest legal row; larger rows are clamped
    localparam int CNT_W   = 16;   // width of the pixel write counter

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } plot_state_t;

endpackage : trace_pkg

// File: rtl/span_stepper.sv
// ---------------------------------------------------------------------------
// span_stepper
//   Walks one vertical span of a trace, one row per advance, from the row next
//   to the previous point toward the new point's row.
//   Ports:
//     clk, reset  clock and asynchronous active-high reset
//     load        start a new span (point accepted this cycle)
//     span_en     draw a span from prev_y; low means a single pixel at new_y
//     prev_y      row of the previous point
//     new_y       clamped row of the new point (span target)
//     advance     current row was written this cycle
//     cur_y       row to write now
//     last        cur_y has reached the target row
// ---------------------------------------------------------------------------
module span_stepper #(
    parameter int COORD_W = trace_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               span_en,
    input  logic [COORD_W-1:0] prev_y,
    input  logic [COORD_W-1:0] new_y,
    input  logic               advance,
    output logic [COORD_W-1:0] cur_y,
    output logic               last
);

    logic [COORD_W-1:0] cur_q;
    logic [COORD_W-1:0] target_q;
    logic               down_q;    // 1: stepping toward smaller rows

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_q    <= '0;
            target_q <= '0;
            down_q   <= 1'b0;
        end else if (load) begin
            target_q <= new_y;
            if (!span_en || (new_y == prev_y)) begin
                cur_q  <= new_y;
                down_q <= 1'b0;
            end else if (new_y > prev_y) begin
                // prev_y < new_y <= max, so +1 cannot wrap
                cur_q  <= prev_y + 1'b1;
                down_q <= 1'b0;
            end else begin
                // prev_y > new_y >= 0, so -1 cannot wrap
                cur_q  <= prev_y - 1'b1;
                down_q <= 1'b1;
            end
        end else if (advance && !last) begin
            cur_q <= down_q ? (cur_q - 1'b1) : (cur_q + 1'b1);
        end
    end

    assign cur_y = cur_q;
    assign last  = (cur_q == target_q);

endmodule : span_stepper

// File: rtl/trace_plotter.sv
// ---------------------------------------------------------------------------
// trace_plotter
//   Turns waveform points (x, y, colour) into framebuffer pixel writes. Each
//   point fills the vertical run from the previous point's row to its own row
//   at its own column, so steep edges render as continuous lines.
//   Ports:
//     clk, reset     clock and asynchronous active-high reset
//     pt_valid/ready point handshake; ready only while idle
//     pt_x, pt_y     point column and (unclamped) row
//     pt_color       point colour
//     pt_first       point starts a new trace: no span from previous point
//     fb_we/ready    framebuffer write handshake, one pixel per handshake
//     fb_addr        {y, x} pixel address
//     fb_wdata       pixel colour
//     busy           span being written
//     pix_count      pixels written since reset, saturating
// ---------------------------------------------------------------------------
module trace_plotter #(
    parameter int COORD_W = trace_pkg::COORD_W,
    parameter int COLOR_W = trace_pkg::COLOR_W,
    parameter int Y_MAX   = trace_pkg::Y_MAX,
    parameter int CNT_W   = trace_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pt_valid,
    output logic                 pt_ready,
    input  logic [COORD_W-1:0]   pt_x,
    input  logic [COORD_W-1:0]   pt_y,
    input  logic [COLOR_W-1:0]   pt_color,
    input  logic                 pt_first,
    output logic                 fb_we,
    input  logic                 fb_ready,
    output logic [2*COORD_W-1:0] fb_addr,
    output logic [COLOR_W-1:0]   fb_wdata,
    output logic                 busy,
    output logic [CNT_W-1:0]     pix_count
);

    import trace_pkg::*;

    localparam logic [COORD_W-1:0] Y_LIMIT = COORD_W'(Y_MAX);

    plot_state_t         state;
    plot_state_t         state_next;
    logic [COORD_W-1:0]  y_clamped;
    logic [COORD_W-1:0]  x_q;
    logic [COLOR_W-1:0]  color_q;
    logic [COORD_W-1:0]  prev_y;
    logic                have_prev;
    logic [CNT_W-1:0]    count_q;
    logic [COORD_W-1:0]  cur_y;
    logic                last;
    logic                accept;
    logic                handshake;

    assign y_clamped = (pt_y > Y_LIMIT) ? Y_LIMIT : pt_y;
    assign accept    = pt_valid && pt_ready;
    assign handshake = fb_we && fb_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pt_ready   = 1'b0;
        fb_we      = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                pt_ready = 1'b1;
                if (pt_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                fb_we = 1'b1;
                busy  = 1'b1;
                // last pixel written: back to IDLE right after the handshake
                if (fb_ready && last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- point latch, trace history, counter ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            color_q   <= '0;
            prev_y    <= '0;
            have_prev <= 1'b0;
            count_q   <= '0;
        end else begin
            if (accept) begin
                x_q     <= pt_x;
                color_q <= pt_color;
            end
            if (handshake) begin
                if (count_q != '1) begin
                    count_q <= count_q + 1'b1;
                end
                if (last) begin
                    prev_y    <= cur_y;
                    have_prev <= 1'b1;
                end
            end
        end
    end

    span_stepper #(
        .COORD_W (COORD_W)
    ) u_span_stepper (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .span_en (have_prev && !pt_first),
        .prev_y  (prev_y),
        .new_y   (y_clamped),
        .advance (handshake),
        .cur_y   (cur_y),
        .last    (last)
    );

    // Address and data come straight from registers, so they hold steady
    // through any number of fb_ready stalls.
    assign fb_addr   = {cur_y, x_q};
    assign fb_wdata  = color_q;
    assign pix_count = count_q;

endmodule : trace_plotter
